glb_rd_port: RTL and testbench

- GLB-side responder for the coordinate and distance read channels that the point-search controller issues: address valid/ready in, data valid/ready out.
- Translates a logical point index into a physical SRAM address using a configured base, and issues synchronous SRAM reads.
- Tracks in-flight reads with credits and buffers returned words in a small first-word-fall-through (FWFT) FIFO. The address channel therefore never overruns the data channel under back-pressure.
- One instance serves each read channel (Crd, DistIdx).

---
 rtl/glb_pkg.sv | 19 +
 rtl/glb_rd_fifo.sv | 63 ++++++
 rtl/glb_rd_port.sv | 134 +++++++++++++
 tb/tb_glb_rd_port.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glb_pkg.sv
// Shared defaults and address helper for the GLB read ports.
// The optional bounds check in glb_rd_port is enabled by defining GLB_RD_ERR_EN.
package glb_pkg;

  localparam int SRAM_WIDTH_DEF = 256;
  localparam int ADDR_WIDTH_DEF = 10;
  localparam int SRAM_DEPTH_DEF = 1024;
  localparam int RD_LATENCY_MAX = 4;

  // Base + index, wrapped to the SRAM depth; callers truncate to their address width.
  function automatic logic [31:0] wrap_addr(input logic [31:0] base,
                                            input logic [31:0] idx,
                                            input logic [31:0] depth);
    logic [31:0] sum;
    sum = base + idx;
    return sum % depth;
  endfunction

endpackage

// File: rtl/glb_rd_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and clear.
// Works for any DEPTH >= 1 (pointers wrap explicitly, not by power of two).
module glb_rd_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 3,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop && (cnt != '0);
  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_push = push && ((cnt != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= push_dat;
  end

  assign head  = mem[rd_ptr];
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/glb_rd_port.sv
// GLB read responder: index->SRAM address, credit-limited issue, FWFT return buffer.
// Define GLB_RD_ERR_EN to bounds-check RdAddr against CfgNum (zero word + sticky RdErr).
module glb_rd_port
  import glb_pkg::*;
#(
  parameter int SRAM_WIDTH = SRAM_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int SRAM_DEPTH = SRAM_DEPTH_DEF,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = RD_LATENCY + 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Clr,
  input  logic [ADDR_WIDTH-1:0] CfgBase,
  input  logic [ADDR_WIDTH-1:0] CfgNum,
  input  logic [ADDR_WIDTH-1:0] RdAddr,
  input  logic                  RdAddrVld,
  output logic                  RdAddrRdy,
  output logic [SRAM_WIDTH-1:0] RdDat,
  output logic                  RdDatVld,
  input  logic                  RdDatRdy,
  output logic                  SramRdEn,
  output logic [ADDR_WIDTH-1:0] SramAddr,
  input  logic [SRAM_WIDTH-1:0] SramRdDat,
  output logic                  RdErr,
  output logic                  Busy
);

  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_W  = $clog2(2 * FIFO_DEPTH + 1);

  logic [RD_LATENCY-1:0] vld_sr;
  logic [CNT_W-1:0]      inflight_cnt;
  logic [CNT_W-1:0]      credit_cnt;
  logic [FCNT_W-1:0]     fifo_cnt;
  logic                  fifo_empty;
  logic [SRAM_WIDTH-1:0] fifo_head;
  logic [SRAM_WIDTH-1:0] push_dat;
  logic [ADDR_WIDTH-1:0] phys_addr;
  logic                  accept;
  logic                  issue;
  logic                  oob;
  logic                  push;
  logic                  pop;

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight_cnt = inflight_cnt + CNT_W'(vld_sr[i]);
    end
  end

  // Every accepted request owns a FIFO slot until popped, so the buffer cannot overflow.
  assign credit_cnt = inflight_cnt + CNT_W'(fifo_cnt);
  assign RdAddrRdy  = !Clr && (credit_cnt < CNT_W'(FIFO_DEPTH));
  assign accept     = RdAddrVld && RdAddrRdy;
  assign issue      = accept && !oob;

  assign phys_addr = ADDR_WIDTH'(wrap_addr(32'(CfgBase), 32'(RdAddr), 32'(SRAM_DEPTH)));
  assign SramRdEn  = issue;
  assign SramAddr  = issue ? phys_addr : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
    end else if (Clr) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= accept;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
    end
  end

`ifdef GLB_RD_ERR_EN
  logic [RD_LATENCY-1:0] err_sr;
  logic                  rd_err;

  assign oob = (RdAddr >= CfgNum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sr <= '0;
      rd_err <= 1'b0;
    end else if (Clr) begin
      err_sr <= '0;
      rd_err <= 1'b0;
    end else begin
      err_sr[0] <= accept && oob;
      for (int i = 1; i < RD_LATENCY; i++) begin
        err_sr[i] <= err_sr[i-1];
      end
      if (accept && oob) rd_err <= 1'b1;
    end
  end

  // Out-of-range slots never read SRAM; they return a zero word in order.
  assign push_dat = err_sr[RD_LATENCY-1] ? '0 : SramRdDat;
  assign RdErr    = rd_err;
`else
  logic unused_cfg_num;

  assign oob            = 1'b0;
  assign push_dat       = SramRdDat;
  assign RdErr          = 1'b0;
  assign unused_cfg_num = ^CfgNum;
`endif

  assign push = vld_sr[RD_LATENCY-1] && !Clr;
  assign pop  = RdDatVld && RdDatRdy && !Clr;

  glb_rd_fifo #(
    .WIDTH (SRAM_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (Clr),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  assign RdDatVld = !fifo_empty;
  // Storage is not reset, so the head is masked to keep RdDat at zero when empty.
  assign RdDat    = RdDatVld ? fifo_head : '0;
  assign Busy     = (credit_cnt != '0);

endmodule

// File: tb/tb_glb_rd_port.sv
// Self-checking bench for glb_rd_port (RD_LATENCY=2): vector table, corner sequences, random stall.
// Out-of-range checks run only when GLB_RD_ERR_EN is defined.
module tb_glb_rd_port;

  localparam int AW      = 10;
  localparam int SW      = 256;
  localparam int DEPTH_S = 1024;
  localparam int L       = 2;
  localparam int FD      = L + 2;
`ifdef GLB_RD_ERR_EN
  localparam bit ERR_EN  = 1'b1;
`else
  localparam bit ERR_EN  = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          Clr;
  logic [AW-1:0] CfgBase;
  logic [AW-1:0] CfgNum;
  logic [AW-1:0] RdAddr;
  logic          RdAddrVld;
  logic          RdAddrRdy;
  logic [SW-1:0] RdDat;
  logic          RdDatVld;
  logic          RdDatRdy;
  logic          SramRdEn;
  logic [AW-1:0] SramAddr;
  logic [SW-1:0] SramRdDat;
  logic          RdErr;
  logic          Busy;

  glb_rd_port #(
    .SRAM_WIDTH (SW),
    .ADDR_WIDTH (AW),
    .SRAM_DEPTH (DEPTH_S),
    .RD_LATENCY (L),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Clr       (Clr),
    .CfgBase   (CfgBase),
    .CfgNum    (CfgNum),
    .RdAddr    (RdAddr),
    .RdAddrVld (RdAddrVld),
    .RdAddrRdy (RdAddrRdy),
    .RdDat     (RdDat),
    .RdDatVld  (RdDatVld),
    .RdDatRdy  (RdDatRdy),
    .SramRdEn  (SramRdEn),
    .SramAddr  (SramAddr),
    .SramRdDat (SramRdDat),
    .RdErr     (RdErr),
    .Busy      (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM contents are a fixed function of the address; nonzero everywhere.
  function automatic logic [SW-1:0] sram_word(input int a);
    logic [SW-1:0] w;
    for (int k = 0; k < 8; k++) w[k*32 +: 32] = 32'(a) * 32'h9E3779B1 + 32'(k) * 32'h01010101 + 32'h1;
    return w;
  endfunction

  // SRAM model: a read issued in cycle t drives its word during cycle t+L, junk otherwise.
  logic [AW-1:0] pa [L];
  logic          pv [L];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < L; i++) begin pv[i] <= 1'b0; pa[i] <= '0; end
    end else begin
      pv[0] <= SramRdEn;
      pa[0] <= SramAddr;
      for (int i = 1; i < L; i++) begin pv[i] <= pv[i-1]; pa[i] <= pa[i-1]; end
    end
  end
  assign SramRdDat = pv[L-1] ? sram_word(int'(pa[L-1])) : {8{32'hDEADBEEF}};

  // Reference model: outstanding requests in order, each with the cycle it may first appear.
  typedef struct {
    logic [SW-1:0] dat;
    int            rdy_cyc;
  } exp_t;
  exp_t q[$];
  logic err_m;
  int   cyc;

  int n_chk;
  int n_fail;
  int n_pop;

  logic          d_rdy, d_vld, d_en, d_busy, d_err, d_acc, d_pop;
  logic [SW-1:0] d_dat;
  logic [AW-1:0] d_addr;

  task automatic chk(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input logic v, input logic [AW-1:0] a, input logic r, input logic c);
    logic          e_rdy, e_vld, e_oob, e_acc, e_pop;
    logic [AW-1:0] e_addr;
    @(negedge clk);
    RdAddrVld = v;
    RdAddr    = a;
    RdDatRdy  = r;
    Clr       = c;
    #1;
    e_rdy  = !c && (q.size() < FD);
    e_vld  = (q.size() != 0) && (cyc >= q[0].rdy_cyc);
    e_oob  = ERR_EN && (a >= CfgNum);
    e_acc  = v && e_rdy;
    e_pop  = e_vld && r && !c;
    e_addr = AW'((int'(CfgBase) + int'(a)) % DEPTH_S);
    d_rdy  = RdAddrRdy;
    d_vld  = RdDatVld;
    d_dat  = RdDat;
    d_en   = SramRdEn;
    d_addr = SramAddr;
    d_busy = Busy;
    d_err  = RdErr;
    d_acc  = RdAddrVld && RdAddrRdy;
    d_pop  = RdDatVld && RdDatRdy && !Clr;
    chk("rd_addr_rdy", d_rdy, e_rdy);
    chk("rd_dat_vld", d_vld, e_vld);
    if (e_vld && d_vld) chk("rd_dat", d_dat, q[0].dat);
    chk("sram_rd_en", d_en, e_acc && !e_oob);
    if (e_acc && !e_oob && d_en) chk("sram_addr", d_addr, e_addr);
    chk("busy", d_busy, q.size() != 0);
    chk("rd_err", d_err, err_m);
    if (d_pop) n_pop++;
    @(posedge clk);
    if (c) begin
      q.delete();
      err_m = 1'b0;
    end else begin
      if (e_pop) void'(q.pop_front());
      if (e_acc) begin
        q.push_back('{dat: (e_oob ? '0 : sram_word(int'(e_addr))), rdy_cyc: cyc + L + 1});
        if (e_oob) err_m = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      step(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] idx;
    logic [AW-1:0] exp_addr;
  } vec_t;
  vec_t vecs [24];
  int   wrap_exp [8];

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_acc;
    int pops0;
    logic [AW-1:0] ridx;
    n_chk = 0; n_fail = 0; n_pop = 0; cyc = 0; err_m = 1'b0;
    rst_n = 1'b0; Clr = 1'b0; RdAddrVld = 1'b0; RdAddr = '0; RdDatRdy = 1'b0;
    CfgBase = '0; CfgNum = 10'd16;

    wrap_exp = '{1020, 1021, 1022, 1023, 0, 1, 2, 3};
    for (int i = 0; i < 16; i++) vecs[i] = '{base: '0, idx: AW'(i), exp_addr: AW'(i)};
    for (int i = 0; i < 8; i++) vecs[16+i] = '{base: 10'd1020, idx: AW'(i), exp_addr: AW'(wrap_exp[i])};

    repeat (2) @(negedge clk);
    #1;
    chk("reset_rdy", RdAddrRdy, 1'b1);
    chk("reset_vld", RdDatVld, 1'b0);
    chk("reset_dat", RdDat, '0);
    chk("reset_en", SramRdEn, 1'b0);
    chk("reset_addr", SramAddr, '0);
    chk("reset_err", RdErr, 1'b0);
    chk("reset_busy", Busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming (base 0) then wrap (base 1020), back-to-back with the consumer always ready.
    for (int i = 0; i < 24; i++) begin
      if (vecs[i].base != CfgBase) begin
        drain(20);
        CfgBase = vecs[i].base;
      end
      step(1'b1, vecs[i].idx, 1'b1, 1'b0);
      chk("vec_accept", d_acc, 1'b1);
      chk("vec_sram_addr", d_addr, vecs[i].exp_addr);
    end
    drain(20);

    // Back-pressure: consumer stalled, only FD requests fit.
    CfgBase = 10'd100;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, AW'(i), 1'b0, 1'b0);
      n_acc += int'(d_acc);
    end
    chk("bp_accepts", n_acc, FD);
    chk("bp_rdy_low", d_rdy, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("bp_first_pop", d_pop, 1'b1);
    chk("bp_rdy_at_pop", d_rdy, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("bp_rdy_after_pop", d_rdy, 1'b1);
    drain(20);

    // Clr with two words buffered and two reads in flight.
    for (int i = 0; i < 4; i++) step(1'b1, AW'(10 + i), 1'b0, 1'b0);
    chk("clr_pre_busy", d_busy, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("clr_cycle_rdy", d_rdy, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("clr_vld", d_vld, 1'b0);
    chk("clr_busy", d_busy, 1'b0);
    repeat (L) step(1'b0, '0, 1'b1, 1'b0);
    chk("clr_late_vld", d_vld, 1'b0);
    step(1'b1, 10'd14, 1'b1, 1'b0);
    drain(20);

    // Random stall: 200 requests, random valid/ready, random base and indices.
    CfgBase = AW'($urandom_range(0, DEPTH_S - 1));
    CfgNum  = 10'd600;
    n_acc = 0;
    pops0 = n_pop;
    ridx  = AW'($urandom_range(0, DEPTH_S - 1));
    for (int n = 0; n < 4000 && n_acc < 200; n++) begin
      step(($urandom_range(0, 3) != 0), ridx, $urandom_range(0, 1) == 1, 1'b0);
      if (d_acc) begin
        n_acc++;
        ridx = AW'($urandom_range(0, DEPTH_S - 1));
      end
    end
    chk("rand_accepts", n_acc, 200);
    drain(40);
    chk("rand_pops", n_pop - pops0, n_acc);
    step(1'b0, '0, 1'b1, 1'b1);

`ifdef GLB_RD_ERR_EN
    CfgBase = '0;
    CfgNum  = 10'd8;
    step(1'b1, 10'd9, 1'b0, 1'b0);
    chk("err_accept", d_acc, 1'b1);
    chk("err_no_sram_rd", d_en, 1'b0);
    repeat (L + 1) step(1'b0, '0, 1'b0, 1'b0);
    chk("err_vld", d_vld, 1'b1);
    chk("err_zero_word", d_dat, '0);
    chk("err_flag", d_err, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    repeat (3) step(1'b0, '0, 1'b0, 1'b0);
    chk("err_hold", d_err, 1'b1);
    step(1'b1, 10'd3, 1'b1, 1'b0);
    chk("err_in_range_rd", d_en, 1'b1);
    drain(20);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("err_clr", d_err, 1'b0);
`endif

    // Reset with requests outstanding.
    CfgNum = 10'd16;
    step(1'b1, 10'd1, 1'b0, 1'b0);
    step(1'b1, 10'd2, 1'b0, 1'b0);
    @(negedge clk);
    RdAddrVld = 1'b0;
    RdDatRdy  = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("mid_reset_busy", Busy, 1'b0);
    chk("mid_reset_vld", RdDatVld, 1'b0);
    chk("mid_reset_rdy", RdAddrRdy, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    err_m = 1'b0;
    step(1'b1, 10'd5, 1'b1, 1'b0);
    drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
